// File: rtl/ifu_fetch.sv
// Instruction fetch unit: captures the PC, issues a single-outstanding read on the
// instruction bus and presents the returned word to decode with a skid slot for stalls.
module ifu_fetch #(
  parameter int             AW       = 32,
  parameter int             DW       = 32,
  parameter logic [DW-1:0]  NOP_INST = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_i,
  input  logic          jump_flag_i,
  output logic          hold_flag_o,
  output logic          ibus_req_o,
  output logic [AW-1:0] ibus_addr_o,
  input  logic          ibus_gnt_i,
  input  logic          ibus_rvalid_i,
  input  logic [DW-1:0] ibus_rdata_i,
  input  logic          ibus_err_i,
  input  logic          stall_i,
  output logic          inst_valid_o,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_addr_o,
  output logic          inst_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, SKID} state_t;

  state_t        state;
  logic          kill_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] skid_data;
  logic          skid_err;

  logic buf_free;
  logic consume;
  logic rsp_ok;
  logic cap;

  assign buf_free = !inst_valid_o || !stall_i;
  assign consume  = inst_valid_o && !stall_i;
  assign rsp_ok   = (state == WAIT) && ibus_rvalid_i && !kill_q;

  // A new PC is taken only when the current one is fully handed off (or never issued).
  always_comb begin
    cap = 1'b0;
    if (!jump_flag_i) begin
      case (state)
        IDLE:    cap = 1'b1;
        WAIT:    cap = rsp_ok && buf_free;
        SKID:    cap = buf_free;
        default: cap = 1'b0;
      endcase
    end
  end

  assign hold_flag_o = !(cap && rst_n);
  assign ibus_addr_o = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      kill_q       <= 1'b0;
      addr_q       <= '0;
      skid_data    <= '0;
      skid_err     <= 1'b0;
      ibus_req_o   <= 1'b0;
      inst_valid_o <= 1'b0;
      inst_o       <= '0;
      inst_addr_o  <= '0;
      inst_err_o   <= 1'b0;
    end else if (jump_flag_i) begin
      // Flush: an ungranted request must stay up, so its response is killed instead.
      inst_valid_o <= 1'b0;
      case (state)
        REQ: begin
          kill_q <= 1'b1;
          if (ibus_gnt_i) begin
            ibus_req_o <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (ibus_rvalid_i) begin
            kill_q <= 1'b0;
            state  <= IDLE;
          end else begin
            kill_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      if (consume)
        inst_valid_o <= 1'b0;
      if (cap) begin
        addr_q     <= pc_i;
        ibus_req_o <= 1'b1;
        state      <= REQ;
      end
      case (state)
        REQ: begin
          if (ibus_gnt_i) begin
            ibus_req_o <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (ibus_rvalid_i) begin
            if (kill_q) begin
              kill_q <= 1'b0;
              state  <= IDLE;
            end else if (buf_free) begin
              inst_valid_o <= 1'b1;
              inst_o       <= ibus_err_i ? NOP_INST : ibus_rdata_i;
              inst_addr_o  <= addr_q;
              inst_err_o   <= ibus_err_i;
            end else begin
              skid_data <= ibus_rdata_i;
              skid_err  <= ibus_err_i;
              state     <= SKID;
            end
          end
        end
        SKID: begin
          // addr_q still names the skid entry here; cap overwrites it only after this edge
          if (buf_free) begin
            inst_valid_o <= 1'b1;
            inst_o       <= skid_err ? NOP_INST : skid_data;
            inst_addr_o  <= addr_q;
            inst_err_o   <= skid_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: plays pc_reg and the instruction memory, and checks the delivered
// instruction stream against the expected PC sequence (flushed on jumps and resets).
module tb_ifu_fetch;
  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] pc_i = '0;
  logic          jump_flag_i = 1'b0;
  logic          hold_flag_o;
  logic          ibus_req_o;
  logic [AW-1:0] ibus_addr_o;
  logic          ibus_gnt_i = 1'b0;
  logic          ibus_rvalid_i = 1'b0;
  logic [DW-1:0] ibus_rdata_i = '0;
  logic          ibus_err_i = 1'b0;
  logic          stall_i = 1'b0;
  logic          inst_valid_o;
  logic [DW-1:0] inst_o;
  logic [AW-1:0] inst_addr_o;
  logic          inst_err_o;

  always #5 clk = ~clk;

  ifu_fetch #(.AW(AW), .DW(DW), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .jump_flag_i(jump_flag_i),
    .hold_flag_o(hold_flag_o), .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
    .ibus_gnt_i(ibus_gnt_i), .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .ibus_err_i(ibus_err_i), .stall_i(stall_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_err_o(inst_err_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    int          epoch;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int epoch = 0, cyc = 0, first_valid = -1, delivered = 0, total = 0;

  int gnt_pct, stall_pct, jump_pct, max_dly;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          dly = 0;
  logic [31:0] tgt = '0;
  logic        hold_s, jump_s, granted_s, rsp_s;
  logic [31:0] gaddr_s;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return ((a >> 2) % 9) == 7;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Capture side: every cycle pc_reg is allowed to advance, that PC is owed to decode.
  always @(negedge clk) begin
    exp_t n;
    if (rst_n && !hold_flag_o) begin
      n.addr  = pc_i;
      n.epoch = epoch;
      exp_q.push_back(n);
    end
  end

  // Monitor: consumes, bus request stability, no capture on a jump.
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] w;
    logic        er;
    if (!rst_n) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        checks++;
        if (!(ibus_req_o === 1'b1 && ibus_addr_o === prev_addr)) begin
          errors++;
          $display("FAIL req_stable: req=%0b addr=%h expected req=1 addr=%h",
                   ibus_req_o, ibus_addr_o, prev_addr);
        end
      end
      prev_wait = ibus_req_o && !ibus_gnt_i;
      prev_addr = ibus_addr_o;
      if (jump_flag_i) begin
        checks++;
        if (hold_flag_o !== 1'b1) begin
          errors++;
          $display("FAIL hold_on_jump: hold=%0b expected 1", hold_flag_o);
        end
      end
      if (inst_valid_o && first_valid < 0) first_valid = cyc;
      if (inst_valid_o && !stall_i) begin
        while (exp_q.size() > 0 && exp_q[0].epoch < epoch) void'(exp_q.pop_front());
        checks++;
        delivered++;
        total++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_inst: addr=%h inst=%h expected nothing", inst_addr_o, inst_o);
        end else begin
          e  = exp_q.pop_front();
          er = mem_err(e.addr);
          w  = er ? NOP : mem_word(e.addr);
          if (inst_addr_o !== e.addr || inst_o !== w || inst_err_o !== er) begin
            errors++;
            $display("FAIL inst: addr=%h inst=%h err=%0b expected addr=%h inst=%h err=%0b",
                     inst_addr_o, inst_o, inst_err_o, e.addr, w, er);
          end
        end
      end
    end
  end

  // One cycle per iteration: sample the cycle at negedge, then act as pc_reg/memory after the edge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      hold_s    = hold_flag_o;
      jump_s    = jump_flag_i;
      granted_s = ibus_req_o && ibus_gnt_i;
      gaddr_s   = ibus_addr_o;
      rsp_s     = ibus_rvalid_i;
      @(posedge clk);
      #1;
      cyc++;
      if (jump_s) begin
        pc_i = tgt;
        epoch++;
      end else if (!hold_s) begin
        pc_i = pc_i + 32'd4;
      end
      if (rsp_s) pend = 1'b0;
      if (granted_s) begin
        pend      = 1'b1;
        pend_addr = gaddr_s;
        dly       = $urandom_range(0, max_dly);
      end
      if (pend && dly == 0) begin
        ibus_rvalid_i = 1'b1;
        ibus_rdata_i  = mem_word(pend_addr);
        ibus_err_i    = mem_err(pend_addr);
      end else begin
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = $urandom;
        ibus_err_i    = 1'($urandom_range(0, 1));
        if (pend) dly--;
      end
      ibus_gnt_i  = ibus_req_o && ($urandom_range(1, 100) <= gnt_pct);
      stall_i     = ($urandom_range(1, 100) <= stall_pct);
      jump_flag_i = ($urandom_range(1, 100) <= jump_pct);
      tgt         = 32'($urandom_range(0, 4095)) << 2;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(inst_valid_o), 64'd0);
    chk({tag, "_req"},   64'(ibus_req_o),   64'd0);
    chk({tag, "_inst"},  64'(inst_o),       64'd0);
    chk({tag, "_iaddr"}, 64'(inst_addr_o),  64'd0);
    chk({tag, "_err"},   64'(inst_err_o),   64'd0);
    chk({tag, "_hold"},  64'(hold_flag_o),  64'd1);
  endtask

  // Called just after a posedge; releases reset and drives cycle 0 (optionally with a late rvalid).
  task automatic release_rst(input bit late);
    rst_n       = 1'b1;
    cyc         = 0;
    first_valid = -1;
    delivered   = 0;
    ibus_gnt_i  = 1'b0;
    stall_i     = 1'b0;
    jump_flag_i = 1'b0;
    if (late) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = 32'hBAD0BAD0;
      ibus_err_i    = 1'b0;
    end else begin
      ibus_rvalid_i = 1'b0;
    end
    pend = 1'b0;
  endtask

  initial begin
    bit found;
    #2;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1;
    release_rst(1'b0);

    // zero-wait memory: first valid at cycle 3, then one every 2 cycles
    gnt_pct = 100; stall_pct = 0; jump_pct = 0; max_dly = 0;
    run(20);
    chk("p1_first_valid", 64'(first_valid), 64'd3);
    chk("p1_count", 64'(delivered), 64'd9);

    gnt_pct = 60; stall_pct = 30; jump_pct = 5; max_dly = 3;
    run(3000);
    chk("rand_progress", 64'(total >= 100), 64'd1);

    // reset while a granted read is outstanding
    gnt_pct = 100; stall_pct = 0; jump_pct = 0; max_dly = 3;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (pend && !ibus_rvalid_i) found = 1'b1;
      else run(1);
    end
    chk("wait_found", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_wait");
    exp_q.delete();
    pc_i          = '0;
    jump_flag_i   = 1'b0;
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b0;
    stall_i       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    release_rst(1'b1);
    max_dly = 0;
    run(20);
    chk("p6_first_valid", 64'(first_valid), 64'd3);
    chk("p6_count", 64'(delivered), 64'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
